// File: rtl/bs_4_mux21.sv
// bs_4_mux21: 4-bit 2:1 mux built from per-bit mux cells, with a change-detect pulse.
// Define BS_4_MUX21_REG_OUT_EN to register the data output (one-cycle latency).
`default_nettype none

module bs_4_mux21_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_s,
  output logic o_y
);
  assign o_y = (i_a & ~i_s) | (i_b & i_s);
endmodule

module bs_4_mux21 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] data,
  output logic             chg
);

  logic [WIDTH-1:0] w_sel;
  logic [WIDTH-1:0] r_sel_prev;
  logic             r_chg;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    bs_4_mux21_cell u_cell (
      .i_a (a[gi]),
      .i_b (b[gi]),
      .i_s (s),
      .o_y (w_sel[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_prev <= '0;
      r_chg      <= 1'b0;
    end else begin
      r_sel_prev <= w_sel;
      r_chg      <= (w_sel != r_sel_prev);
    end
  end

  assign chg = r_chg;

`ifdef BS_4_MUX21_REG_OUT_EN
  // data_q and chg update on the same edge, so chg marks the cycle data_q changes.
  logic [WIDTH-1:0] r_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= w_sel;
    end
  end

  assign data = r_data_q;
`else
  assign data = w_sel;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bs_4_mux21.sv
// tb_bs_4_mux21: randomized and directed checks of bs_4_mux21 against a behavioural model.
`default_nettype none

module tb_bs_4_mux21;

  logic       clk;
  logic       rst_n;
  logic       s;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] data;
  logic       chg;

  int n_checks;
  int n_fail;

  // Behavioural model state: last sampled selection, pulse, registered data.
  logic [3:0] m_prev;
  logic       m_chg;
  logic [3:0] m_dq;

  bs_4_mux21 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (s),
    .a     (a),
    .b     (b),
    .data  (data),
    .chg   (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] pick(input logic ss, input logic [3:0] aa, input logic [3:0] bb);
    return ss ? bb : aa;
  endfunction

  task automatic model_reset();
    m_prev = 4'b0000;
    m_chg  = 1'b0;
    m_dq   = 4'b0000;
  endtask

  // Apply one input set mid-cycle, check combinational data, clock it, check registered state.
  task automatic step(input string tag, input logic ss, input logic [3:0] aa, input logic [3:0] bb);
    logic [3:0] want;
    @(negedge clk);
    s = ss;
    a = aa;
    b = bb;
    want = pick(ss, aa, bb);
    #1;
`ifndef BS_4_MUX21_REG_OUT_EN
    chk({tag, "_data"}, data, want);
`endif
    @(posedge clk);
    m_chg  = (want != m_prev);
    m_prev = want;
    m_dq   = want;
    #1;
    chk({tag, "_chg"}, {3'b000, chg}, {3'b000, m_chg});
`ifdef BS_4_MUX21_REG_OUT_EN
    chk({tag, "_data"}, data, m_dq);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n = 1'b0;
    s = 1'b0;
    a = 4'b0000;
    b = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_chg", {3'b000, chg}, 4'b0000);
`ifdef BS_4_MUX21_REG_OUT_EN
    chk("reset_data", data, 4'b0000);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic selection.
    step("basic_s0", 1'b0, 4'b0001, 4'b1111);
    step("basic_s1", 1'b1, 4'b0001, 4'b1111);

    // Per-bit independence with alternating select.
    for (int k = 0; k < 6; k++)
      step("alt", k[0], 4'b1010, 4'b0101);

    // Equal operands: no change pulse when select toggles.
    step("eq_init", 1'b0, 4'b0110, 4'b0110);
    for (int k = 0; k < 4; k++)
      step("eq", ~k[0], 4'b0110, 4'b0110);

    // Asynchronous reset between edges with data_q holding 1111.
    step("pre_rst", 1'b0, 4'b1111, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_chg", {3'b000, chg}, 4'b0000);
`ifdef BS_4_MUX21_REG_OUT_EN
    chk("async_rst_data", data, 4'b0000);
`else
    chk("rst_comb_data", data, 4'b1111);
`endif
    #1;
    rst_n = 1'b1;
    step("post_rst1", 1'b0, 4'b0011, 4'b0000);
    step("post_rst2", 1'b0, 4'b0011, 4'b0000);

    // Exhaustive sweep of all select/operand combinations.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = i[8:0];
      step("sweep", v[8], v[7:4], v[3:0]);
    end

    // Random stimulus.
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
